// File: rtl/pdp_rdma_group_sched_if.sv
// Handshake and readback bundle between the PDP RDMA group scheduler, the
// register file (OP_ENABLE writes, status readback) and the datapath.
interface pdp_rdma_group_sched_if;
  logic [1:0] op_en_set;
  logic       op_done;
  logic       op_load;
  logic       op_group;
  logic       consumer;
  logic [1:0] status_0;
  logic [1:0] status_1;
  logic [1:0] op_en;
  logic [1:0] done_intr;
  logic       err_unexp_done;
  logic       err_timeout;

  // Scheduler side
  modport master (
    input  op_en_set,
    input  op_done,
    output op_load,
    output op_group,
    output consumer,
    output status_0,
    output status_1,
    output op_en,
    output done_intr,
    output err_unexp_done,
    output err_timeout
  );

  // Register file / datapath side
  modport slave (
    output op_en_set,
    output op_done,
    input  op_load,
    input  op_group,
    input  consumer,
    input  status_0,
    input  status_1,
    input  op_en,
    input  done_intr,
    input  err_unexp_done,
    input  err_timeout
  );
endinterface

// File: rtl/pdp_rdma_group_sched.sv
// Ping-pong register-group scheduler for the PDP RDMA engine.
// Tracks OP_ENABLE for groups 0/1, launches the group pointed to by the
// consumer pointer, sequences LOAD/RUN/DRAIN and flips the pointer on retire.
module pdp_rdma_group_sched #(
  parameter int unsigned DRAIN_CYC   = 4,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic                           nvdla_core_clk,
  input  logic                           nvdla_core_rst,
  pdp_rdma_group_sched_if.master         grp
);

  localparam int unsigned     DW         = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [DW-1:0]   DRAIN_INIT = DW'(DRAIN_CYC);
  localparam logic [15:0]     WD_LAST    = 16'(TIMEOUT_CYC - 1);
  localparam bit              WD_EN      = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN
  } state_e;

  state_e        state_q;
  logic          consumer_q;
  logic [1:0]    op_en_q;
  logic [1:0]    op_en_d;
  logic          op_load_q;
  logic          err_unexp_q;
  logic          err_timeout_q;
  logic [DW-1:0] drain_cnt_q;
  logic [15:0]   wd_cnt_q;

  logic          wd_expire;
  logic          retire;
  logic          busy;
  logic [1:0]    status_0_w;
  logic [1:0]    status_1_w;
  logic [1:0]    done_intr_w;

  // Retire decode and OP_ENABLE next value; a set landing on the retire
  // cycle of the same group wins over the clear.
  always_comb begin
    wd_expire = WD_EN && (state_q == ST_RUN) && !grp.op_done && (wd_cnt_q == WD_LAST);
    retire    = ((state_q == ST_DRAIN) && (drain_cnt_q == '0)) || wd_expire;
    op_en_d   = op_en_q;
    if (retire) begin
      op_en_d[consumer_q] = 1'b0;
    end
    op_en_d = op_en_d | grp.op_en_set;
  end

  // Sequencer: IDLE -> LOAD -> RUN -> DRAIN -> retire, with registered op_load
  // and sticky error flags.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q       <= ST_IDLE;
      consumer_q    <= 1'b0;
      op_en_q       <= '0;
      op_load_q     <= 1'b0;
      err_unexp_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      drain_cnt_q   <= '0;
      wd_cnt_q      <= '0;
    end else begin
      op_en_q   <= op_en_d;
      op_load_q <= 1'b0;
      if (grp.op_done && (state_q != ST_RUN)) begin
        err_unexp_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          // Only the consumer's group may start; the other group waits its turn.
          if (op_en_q[consumer_q]) begin
            state_q   <= ST_LOAD;
            op_load_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          wd_cnt_q <= '0;
          state_q  <= ST_RUN;
        end
        ST_RUN: begin
          if (grp.op_done) begin
            drain_cnt_q <= DRAIN_INIT;
            state_q     <= ST_DRAIN;
          end else if (wd_expire) begin
            err_timeout_q <= 1'b1;
            consumer_q    <= ~consumer_q;
            state_q       <= ST_IDLE;
          end else if (WD_EN) begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == '0) begin
            consumer_q <= ~consumer_q;
            state_q    <= ST_IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q - DW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Status readback and retire interrupt. done_intr is asserted during the
  // retire cycle itself (needed for the op_done -> done_intr latency of
  // DRAIN_CYC+1), and is masked while reset aborts an operation.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    status_0_w  = !op_en_q[0] ? 2'd0 : ((busy && !consumer_q) ? 2'd1 : 2'd2);
    status_1_w  = !op_en_q[1] ? 2'd0 : ((busy &&  consumer_q) ? 2'd1 : 2'd2);
    done_intr_w = '0;
    if (retire && !nvdla_core_rst) begin
      done_intr_w[consumer_q] = 1'b1;
    end
  end

  assign grp.op_load        = op_load_q;
  assign grp.op_group       = consumer_q;
  assign grp.consumer       = consumer_q;
  assign grp.status_0       = status_0_w;
  assign grp.status_1       = status_1_w;
  assign grp.op_en          = op_en_q;
  assign grp.done_intr      = done_intr_w;
  assign grp.err_unexp_done = err_unexp_q;
  assign grp.err_timeout    = err_timeout_q;

endmodule
